// File: rtl/syscnt_seq_ctrl.sv
// syscnt_seq_ctrl
//
// Sequencing controller for the 4-bit system counter (syscnt). It takes
// START / STOP / CLEAR commands over a valid/ready handshake. It paces
// increments through a programmable prescaler and runs the count up to a
// target value, either once (one-shot) or repeatedly (continuous). It then
// reports completion. The controller does not own the counter: it only
// observes syscnt and drives the counter's increment and clear strobes.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   cmd_valid    in   command present
//   cmd_ready    out  command accepted when cmd_valid && cmd_ready (state only)
//   cmd_op       in   00 NOP, 01 START, 10 STOP, 11 CLEAR
//   cmd_mode     in   0 one-shot, 1 continuous (latched on START)
//   cmd_target   in   terminal count (latched on START)
//   cmd_prescale in   P: one tick every P+1 cycles (latched on START)
//   syscnt       in   current counter value (updates on the edge after a strobe)
//   cnt_en       out  one-cycle increment strobe
//   cnt_clr      out  one-cycle synchronous clear strobe
//   busy         out  high in CLR, RUN and DONE
//   done         out  one-cycle completion / wrap pulse
//   state        out  IDLE=0, CLR=1, RUN=2, DONE=3

module syscnt_seq_ctrl #(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_mode,
  input  logic [CNT_W-1:0] cmd_target,
  input  logic [PRE_W-1:0] cmd_prescale,
  input  logic [CNT_W-1:0] syscnt,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  state_t           state_q;
  logic             start_q;     // CLR continues into RUN (START) or IDLE (CLEAR)
  logic             mode_q;
  logic [CNT_W-1:0] target_q;
  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  logic cmd_acc;
  logic tick;
  logic at_target;
  logic run_step;   // RUN cycle that is not pre-empted by an accepted command

  // A NOP is accepted but treated as if no command had arrived, so it never
  // pre-empts counting.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    cmd_acc   = cmd_valid && cmd_ready && (op_t'(cmd_op) != OP_NOP);
    tick      = (pre_q == prescale_q);
    at_target = (syscnt == target_q);
    run_step  = (state_q == S_RUN) && !cmd_acc;
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
  end

  // Strobes come from the registered state, the live counter value and the
  // command handshake. In continuous mode the wrap at the target replaces the
  // increment with a clear. The wrap is flagged through done in that same cycle.
  always_comb begin
    cnt_en  = run_step && tick && !at_target;
    cnt_clr = (state_q == S_CLR) || (run_step && tick && at_target && mode_q);
    done    = (state_q == S_DONE) || (run_step && tick && at_target && mode_q);
    busy    = (state_q != S_IDLE);
    state   = state_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      mode_q     <= 1'b0;
      target_q   <= '0;
      prescale_q <= '0;
      pre_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_acc) begin
            if (op_t'(cmd_op) == OP_START) begin
              mode_q     <= cmd_mode;
              target_q   <= cmd_target;
              prescale_q <= cmd_prescale;
              start_q    <= 1'b1;
              state_q    <= S_CLR;
            end else if (op_t'(cmd_op) == OP_CLEAR) begin
              start_q <= 1'b0;
              state_q <= S_CLR;
            end
          end
        end

        S_CLR: begin
          pre_q   <= '0;
          state_q <= start_q ? S_RUN : S_IDLE;
        end

        S_RUN: begin
          if (cmd_acc) begin
            case (op_t'(cmd_op))
              OP_START: begin
                mode_q     <= cmd_mode;
                target_q   <= cmd_target;
                prescale_q <= cmd_prescale;
                start_q    <= 1'b1;
                state_q    <= S_CLR;
              end
              OP_CLEAR: begin
                start_q <= 1'b0;
                state_q <= S_CLR;
              end
              default: state_q <= S_IDLE;
            endcase
          end else begin
            pre_q <= pre_d;
            // One-shot completion does not wait for a prescaler tick
            if (at_target && !mode_q) begin
              state_q <= S_DONE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscnt_seq_ctrl.sv
// tb_syscnt_seq_ctrl
//
// Directed bench for syscnt_seq_ctrl. It includes a small model of the 4-bit
// counter, driven by the controller's strobes. The bench walks through the
// reset, one-shot, prescaled, continuous, STOP, CLEAR and mid-run reset cases.
// Its expected values are worked out by hand from the command timing.

module tb_syscnt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_mode = 1'b0;
  logic [3:0] cmd_target = 4'd0;
  logic [7:0] cmd_prescale = 8'd0;
  logic [3:0] syscnt = 4'd7;
  logic       cnt_en;
  logic       cnt_clr;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;
  int enSeen = 0;
  int doneSeen = 0;

  localparam logic [1:0] OP_NOP = 2'b00, OP_START = 2'b01, OP_STOP = 2'b10, OP_CLEAR = 2'b11;

  syscnt_seq_ctrl #(.CNT_W(4), .PRE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mode(cmd_mode), .cmd_target(cmd_target), .cmd_prescale(cmd_prescale),
    .syscnt(syscnt), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .busy(busy), .done(done), .state(state)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Counter datapath model: clear wins over increment, no reset of its own
  always @(posedge clk) begin
    if (cnt_clr) syscnt <= 4'd0;
    else if (cnt_en) syscnt <= syscnt + 4'd1;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance to the next sampling point (falling edge) and tally the strobes
  task automatic stepCycle();
    @(negedge clk);
    if (cnt_en) enSeen++;
    if (done) doneSeen++;
  endtask

  // Present a command at the current falling edge. The caller may check the
  // same-cycle outputs before acceptCmd hands it to the next rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic mode,
                               input logic [3:0] target, input logic [7:0] pre);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_mode = mode;
    cmd_target = target;
    cmd_prescale = pre;
    #1;
  endtask

  task automatic acceptCmd();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = OP_NOP;
    cmd_mode = 1'b1;
    cmd_target = 4'hF;
    cmd_prescale = 8'hFF;
    stepCycle();
  endtask

  task automatic waitSyscnt(input logic [3:0] val, input int budget);
    int n = 0;
    while (syscnt != val && n < budget) begin
      stepCycle();
      n++;
    end
    if (syscnt != val) checkOutput("wait_syscnt_timeout", int'(syscnt), int'(val));
  endtask

  initial begin
    int enCyc[$];
    int doneCyc;
    int errs;
    int expCnt;
    int e0, e1;

    // 1. Reset held for 100 cycles
    rst_n = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_en", cnt_en, 0);
    checkOutput("rst_clr", cnt_clr, 0);
    checkOutput("rst_done", done, 0);

    // 2. One-shot, P=0, target 5
    applyStimulus(OP_START, 1'b0, 4'd5, 8'd0);
    acceptCmd();
    checkOutput("os5_c1_clr", cnt_clr, 1);
    checkOutput("os5_c1_state", state, 1);
    checkOutput("os5_c1_ready", cmd_ready, 0);
    for (int k = 2; k <= 6; k++) begin
      stepCycle();
      checkOutput($sformatf("os5_c%0d_en", k), cnt_en, 1);
      checkOutput($sformatf("os5_c%0d_cnt", k), syscnt, k - 2);
    end
    stepCycle();
    checkOutput("os5_c7_cnt", syscnt, 5);
    checkOutput("os5_c7_en", cnt_en, 0);
    stepCycle();
    checkOutput("os5_c8_done", done, 1);
    checkOutput("os5_c8_state", state, 3);
    checkOutput("os5_c8_busy", busy, 1);
    stepCycle();
    checkOutput("os5_c9_state", state, 0);
    checkOutput("os5_c9_done", done, 0);

    // 3. One-shot, P=3, target 2: increments on RUN cycles 3 and 7 (cycles 5, 9)
    applyStimulus(OP_START, 1'b0, 4'd2, 8'd3);
    acceptCmd();
    doneCyc = -1;
    for (int cyc = 2; cyc <= 12; cyc++) begin
      stepCycle();
      if (cnt_en) enCyc.push_back(cyc);
      if (done) doneCyc = cyc;
    end
    e0 = (enCyc.size() > 0) ? enCyc[0] : -1;
    e1 = (enCyc.size() > 1) ? enCyc[1] : -1;
    checkOutput("pre3_en_count", enCyc.size(), 2);
    checkOutput("pre3_en_first", e0, 5);
    checkOutput("pre3_en_second", e1, 9);
    checkOutput("pre3_done_cycle", doneCyc, 11);
    checkOutput("pre3_final_cnt", syscnt, 2);
    checkOutput("pre3_final_state", state, 0);

    // 4. Continuous, P=0, target 3 for 640 RUN cycles
    applyStimulus(OP_START, 1'b1, 4'd3, 8'd0);
    acceptCmd();
    errs = 0;
    doneSeen = 0;
    for (int cyc = 2; cyc <= 641; cyc++) begin
      stepCycle();
      expCnt = (cyc - 2) % 4;
      if (state != 2'd2) errs++;
      if (int'(syscnt) != expCnt) errs++;
      if (cnt_clr != (expCnt == 3)) errs++;
      if (done != (expCnt == 3)) errs++;
      if (cnt_en != (expCnt != 3)) errs++;
    end
    checkOutput("cont_seq_errors", errs, 0);
    checkOutput("cont_done_count", doneSeen, 160);
    // syscnt is 3 here: STOP must pre-empt the wrap
    applyStimulus(OP_STOP, 1'b0, 4'd0, 8'd0);
    checkOutput("cont_stop_prio_clr", cnt_clr, 0);
    checkOutput("cont_stop_prio_done", done, 0);
    acceptCmd();
    checkOutput("cont_stop_state", state, 0);
    checkOutput("cont_stop_cnt", syscnt, 3);

    // 5. STOP at syscnt=4 during one-shot target 10
    applyStimulus(OP_START, 1'b0, 4'd10, 8'd0);
    acceptCmd();
    waitSyscnt(4'd4, 20);
    doneSeen = 0;
    applyStimulus(OP_STOP, 1'b0, 4'd0, 8'd0);
    checkOutput("stop_prio_en", cnt_en, 0);
    acceptCmd();
    checkOutput("stop_state", state, 0);
    checkOutput("stop_cnt", syscnt, 4);
    repeat (5) stepCycle();
    checkOutput("stop_cnt_hold", syscnt, 4);
    checkOutput("stop_no_done", doneSeen, 0);

    // 6a. CLEAR in RUN goes CLR then IDLE with the counter at 0
    applyStimulus(OP_START, 1'b0, 4'd10, 8'd0);
    acceptCmd();
    repeat (3) stepCycle();
    applyStimulus(OP_CLEAR, 1'b0, 4'd0, 8'd0);
    acceptCmd();
    checkOutput("clr_state", state, 1);
    checkOutput("clr_strobe", cnt_clr, 1);
    stepCycle();
    checkOutput("clr_idle", state, 0);
    checkOutput("clr_cnt", syscnt, 0);

    // 6b. One-shot target 0 completes with no increment
    enSeen = 0;
    doneSeen = 0;
    applyStimulus(OP_START, 1'b0, 4'd0, 8'd0);
    acceptCmd();
    stepCycle();
    checkOutput("t0_run_state", state, 2);
    stepCycle();
    checkOutput("t0_done", done, 1);
    stepCycle();
    checkOutput("t0_idle", state, 0);
    checkOutput("t0_en_total", enSeen, 0);
    checkOutput("t0_done_total", doneSeen, 1);

    // 6c. Continuous target 0 with P=1: clear+done every second cycle
    applyStimulus(OP_START, 1'b1, 4'd0, 8'd1);
    acceptCmd();
    enSeen = 0;
    doneSeen = 0;
    stepCycle();
    checkOutput("ct0_c2_clr", cnt_clr, 0);
    stepCycle();
    checkOutput("ct0_c3_clr", cnt_clr, 1);
    repeat (6) stepCycle();
    checkOutput("ct0_done_total", doneSeen, 4);
    checkOutput("ct0_en_total", enSeen, 0);
    checkOutput("ct0_state", state, 2);
    applyStimulus(OP_STOP, 1'b0, 4'd0, 8'd0);
    acceptCmd();

    // 6d. Reset asserted mid-RUN
    applyStimulus(OP_START, 1'b1, 4'd10, 8'd0);
    acceptCmd();
    repeat (3) stepCycle();
    checkOutput("mrst_pre_state", state, 2);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("mrst_state", state, 0);
    checkOutput("mrst_en", cnt_en, 0);
    checkOutput("mrst_clr", cnt_clr, 0);
    checkOutput("mrst_done", done, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("mrst_after_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
